// File: rtl/gal_pkg.sv
// Shared GAL definitions used by the techmaps and the cycle-accurate sim models.
package gal_pkg;

    localparam bit GAL_OLMC_MODE_COMB = 1'b0;
    localparam bit GAL_OLMC_MODE_REG  = 1'b1;

    localparam int GAL16V8_N  = 8;
    localparam int GAL22V10_N = 10;

endpackage

// File: rtl/gal_olmc_cell.sv
// One GAL output logic macrocell: optional D register with global async reset /
// sync preset, optional output inversion, tristate pin and feedback to the AND array.
module gal_olmc_cell
    import gal_pkg::*;
#(
    parameter bit REGISTERED = GAL_OLMC_MODE_COMB,
    parameter bit INVERTED   = 1'b0
) (
    input  logic C,
    input  logic AR,
    input  logic SP,
    input  logic A,
    input  logic E,
    inout  wire  Y,
    output logic FB
);

    logic e_en;
    logic v;

    // An unknown enable drives the pin rather than smearing X onto the net.
    assign e_en = (E !== 1'b0);

    always_comb begin
        assert (!$isunknown(E)) else $error("gal_olmc_cell: E is X/Z, treated as 1");
    end

    generate
        if (REGISTERED == GAL_OLMC_MODE_REG) begin : g_reg
            logic q_q;
            logic q_d;

            assign q_d = SP | A;

            // AR dominates: it clears at once and holds q at 0 across any edge it covers.
            always_ff @(posedge C or posedge AR) begin
                if (AR) q_q <= 1'b0;
                else    q_q <= q_d;
            end

            assign v  = q_q;
            assign FB = q_q;
        end else begin : g_comb
            logic unused_ctl;
            assign unused_ctl = ^{C, AR, SP};

            assign v  = A;
            // Feedback follows the pin, so an external driver reaches the array when E=0.
            assign FB = e_en ? (v ^ INVERTED) : Y;
        end
    endgenerate

    assign Y = e_en ? (v ^ INVERTED) : 1'bz;

endmodule

// File: rtl/gal_olmc_bank_sim.sv
// Bank of N GAL output macrocells between the SOP arrays and the device pins.
module gal_olmc_bank_sim
    import gal_pkg::*;
#(
    parameter int           N          = GAL16V8_N,
    parameter logic [N-1:0] REGISTERED = '0,
    parameter logic [N-1:0] INVERTED   = '0
) (
    input  logic         C,
    input  logic         AR,
    input  logic         SP,
    input  logic [N-1:0] A,
    input  logic [N-1:0] E,
    inout  wire  [N-1:0] Y,
    output logic [N-1:0] FB
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_cell
            gal_olmc_cell #(
                .REGISTERED (REGISTERED[i]),
                .INVERTED   (INVERTED[i])
            ) u_cell (
                .C  (C),
                .AR (AR),
                .SP (SP),
                .A  (A[i]),
                .E  (E[i]),
                .Y  (Y[i]),
                .FB (FB[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gal_olmc_bank_sim.sv
// Directed and scoreboard checks of the OLMC bank across four mask configurations.
module tb_gal_olmc_bank_sim;

    logic       C = 1'b0;
    logic       AR, SP;
    logic [3:0] A, E;
    logic [3:0] tb_oe, tb_dat;
    wire  [3:0] y_a, y_b, y_c, y_d;
    logic [3:0] fb_a, fb_b, fb_c, fb_d;
    int         errs = 0;
    int         checks = 0;

    localparam logic [3:0] D_REG = 4'b1010;
    localparam logic [3:0] D_INV = 4'b0110;

    always #5 C = ~C;

    gal_olmc_bank_sim #(.N(4), .REGISTERED(4'b0000), .INVERTED(4'b0101)) u_a (
        .C(C), .AR(AR), .SP(SP), .A(A), .E(E), .Y(y_a), .FB(fb_a));
    gal_olmc_bank_sim #(.N(4), .REGISTERED(4'b1111), .INVERTED(4'b0000)) u_b (
        .C(C), .AR(AR), .SP(SP), .A(A), .E(E), .Y(y_b), .FB(fb_b));
    gal_olmc_bank_sim #(.N(4), .REGISTERED(4'b1111), .INVERTED(4'b1111)) u_c (
        .C(C), .AR(AR), .SP(SP), .A(A), .E(E), .Y(y_c), .FB(fb_c));
    gal_olmc_bank_sim #(.N(4), .REGISTERED(D_REG), .INVERTED(D_INV)) u_d (
        .C(C), .AR(AR), .SP(SP), .A(A), .E(E), .Y(y_d), .FB(fb_d));

    // External pin driver on the mixed bank.
    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_drv
            assign y_d[g] = tb_oe[g] ? tb_dat[g] : 1'bz;
        end
    endgenerate

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%b exp=%b @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic mid();
        @(negedge C);
    endtask

    logic [3:0] mq, ey, efb, v;

    initial begin
        AR = 1'b1; SP = 1'b0; A = 4'h0; E = 4'hF; tb_oe = 4'h0; tb_dat = 4'h0;
        #2;
        chk("rst_fb_b", fb_b, 4'h0);
        chk("rst_y_b", y_b, 4'h0);
        chk("rst_y_c", y_c, 4'hF);

        // 1: combinational with inversion, zero latency
        mid();
        A = 4'b0011;
        #1;
        chk("t1_y", y_a, 4'b0110);
        chk("t1_fb", fb_a, 4'b0110);

        // 2: registered, AR pulse then capture
        AR = 1'b0; A = 4'hA;
        #1;
        chk("t2_pre_edge", y_b, 4'h0);
        tick();
        chk("t2_post_edge", y_b, 4'hA);
        mid();
        A = 4'h5;
        #1;
        chk("t2_mid_hold", y_b, 4'hA);
        tick();
        chk("t2_next_edge", y_b, 4'h5);

        // 3: SP wins over A; AR async and dominant over SP
        mid(); A = 4'hA;
        tick();
        chk("t3_q_a", fb_b, 4'hA);
        mid(); SP = 1'b1; A = 4'h0;
        tick();
        chk("t3_sp", fb_b, 4'hF);
        mid(); AR = 1'b1;
        #1;
        chk("t3_ar_async", y_b, 4'h0);
        tick();
        chk("t3_ar_over_sp", fb_b, 4'h0);
        chk("t3_ar_over_sp_y", y_b, 4'h0);

        // 4: inverted registered cells under reset and after
        chk("t4_ar_y", y_c, 4'hF);
        chk("t4_ar_fb", fb_c, 4'h0);
        mid(); AR = 1'b0; SP = 1'b0; A = 4'h3;
        tick();
        chk("t4_y", y_c, 4'hC);
        chk("t4_fb", fb_c, 4'h3);

        // 5: disabled pins: external drive into comb FB, registered FB independent of E
        mid(); A = 4'b0010;
        tick();
        mid();
        A = 4'b0000; E = 4'b1100; tb_oe = 4'b0011; tb_dat = 4'b0011;
        #1;
        chk("t5_y0_ext", {3'b0, y_d[0]}, 4'h1);
        chk("t5_fb0", {3'b0, fb_d[0]}, 4'h1);
        chk("t5_y1_ext", {3'b0, y_d[1]}, 4'h1);
        chk("t5_fb1", {3'b0, fb_d[1]}, 4'h1);
        tb_dat = 4'b0000;
        #1;
        chk("t5_y1_undriven", {3'b0, y_d[1]}, 4'h0);
        chk("t5_fb1_hold", {3'b0, fb_d[1]}, 4'h1);

        // 6: mixed bank against a reference model
        mid(); AR = 1'b1;
        #1;
        mq = 4'h0;
        AR = 1'b0;
        for (int n = 0; n < 200; n++) begin
            mid();
            A = 4'($urandom); E = 4'($urandom); SP = ($urandom_range(0, 7) == 0);
            AR = ($urandom_range(0, 15) == 0);
            tb_dat = 4'($urandom); tb_oe = ~E;
            if (AR) mq = 4'h0;
            #1;
            v   = (D_REG & mq) | (~D_REG & A);
            ey  = (E & (v ^ D_INV)) | (~E & tb_dat);
            efb = (D_REG & mq) | (~D_REG & ey);
            chk("t6_y_mid", y_d, ey);
            chk("t6_fb_mid", fb_d, efb);
            @(posedge C);
            if (AR) mq = 4'h0;
            else    mq = D_REG & (SP ? 4'hF : A);
            #1;
            v   = (D_REG & mq) | (~D_REG & A);
            ey  = (E & (v ^ D_INV)) | (~E & tb_dat);
            efb = (D_REG & mq) | (~D_REG & ey);
            chk("t6_y_edge", y_d, ey);
            chk("t6_fb_edge", fb_d, efb);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
